// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared ALU encodings and ALU-control decode for the EX stage
// Optional feature macro: EXECUTE_NOR_EN (adds funct 0x27 NOR decode).
package execute_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_SEL_ADD  = 4'h0,
    ALU_SEL_SUB  = 4'h1,
    ALU_SEL_AND  = 4'h2,
    ALU_SEL_OR   = 4'h3,
    ALU_SEL_SLT  = 4'h4,
    ALU_SEL_NOR  = 4'h5,
    ALU_SEL_NONE = 4'hF
  } alu_sel_e;

  // Unsupported funct codes map to ALU_SEL_NONE, which forces a zero result.
  function automatic alu_sel_e alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_sel_e sel;
    sel = ALU_SEL_ADD;
    case (aluop)
      ALUOP_ADD, ALUOP_ADD2: sel = ALU_SEL_ADD;
      ALUOP_SUB:             sel = ALU_SEL_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: sel = ALU_SEL_ADD;
          FUNCT_SUB: sel = ALU_SEL_SUB;
          FUNCT_AND: sel = ALU_SEL_AND;
          FUNCT_OR:  sel = ALU_SEL_OR;
          FUNCT_SLT: sel = ALU_SEL_SLT;
`ifdef EXECUTE_NOR_EN
          FUNCT_NOR: sel = ALU_SEL_NOR;
`endif
          default:   sel = ALU_SEL_NONE;
        endcase
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/execute_stage_alu_unit.sv
// rtl/execute_stage_alu_unit.sv - combinational ALU control decode, 32-bit ALU and zero detect
// Optional feature macro: EXECUTE_NOR_EN (handled in the package decode).
module alu_unit
  import execute_stage_pkg::*;
(
  input  logic [1:0]        aluop_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  alu_sel_e sel;
  logic     slt_bit;

  assign sel     = alu_decode(aluop_i, funct_i);
  assign slt_bit = ($signed(a_i) < $signed(b_i));

  always_comb begin
    result_o = '0;
    case (sel)
      ALU_SEL_ADD: result_o = a_i + b_i;
      ALU_SEL_SUB: result_o = a_i - b_i;
      ALU_SEL_AND: result_o = a_i & b_i;
      ALU_SEL_OR:  result_o = a_i | b_i;
      ALU_SEL_SLT: result_o = {{(DATA_W-1){1'b0}}, slt_bit};
      ALU_SEL_NOR: result_o = ~(a_i | b_i);
      default:     result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - MIPS EX stage: operand/dest muxes, branch adder, ALU and EX/MEM register
// Optional feature macro: EXECUTE_NOR_EN (funct 0x27 NOR support).
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wb_ctl,
  input  logic [2:0]        m_ctl,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] npcout,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extendout,
  input  logic [REG_W-1:0]  instrout_2016,
  input  logic [REG_W-1:0]  instrout_1511,
  output logic [1:0]        wb_ctlout,
  output logic              branch,
  output logic              memread,
  output logic              memwrite,
  output logic [DATA_W-1:0] EX_MEM_NPC,
  output logic              zero,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] rdata2out,
  output logic [REG_W-1:0]  five_bit_muxout
);

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  logic [1:0]        wb_ctl_q,   wb_ctl_d;
  logic [2:0]        m_ctl_q,    m_ctl_d;
  logic [DATA_W-1:0] npc_q,      npc_d;
  logic              zero_q,     zero_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic [DATA_W-1:0] rdata2_q,   rdata2_d;
  logic [REG_W-1:0]  dest_q,     dest_d;

  assign alu_b = alusrc ? s_extendout : rdata2;

  alu_unit u_alu (
    .aluop_i  (aluop),
    .funct_i  (s_extendout[5:0]),
    .a_i      (rdata1),
    .b_i      (alu_b),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );

  // Word offset: the two top bits of the immediate fall off the shift.
  always_comb begin
    wb_ctl_d = wb_ctl;
    m_ctl_d  = m_ctl;
    npc_d    = npcout + {s_extendout[DATA_W-3:0], 2'b00};
    zero_d   = alu_zero;
    result_d = alu_res;
    rdata2_d = rdata2;
    dest_d   = regdst ? instrout_1511 : instrout_2016;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ctl_q <= '0;
      m_ctl_q  <= '0;
      npc_q    <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
      rdata2_q <= '0;
      dest_q   <= '0;
    end else begin
      wb_ctl_q <= wb_ctl_d;
      m_ctl_q  <= m_ctl_d;
      npc_q    <= npc_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      rdata2_q <= rdata2_d;
      dest_q   <= dest_d;
    end
  end

  assign wb_ctlout       = wb_ctl_q;
  assign branch          = m_ctl_q[2];
  assign memread         = m_ctl_q[1];
  assign memwrite        = m_ctl_q[0];
  assign EX_MEM_NPC      = npc_q;
  assign zero            = zero_q;
  assign alu_result      = result_q;
  assign rdata2out       = rdata2_q;
  assign five_bit_muxout = dest_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed and randomized checks of execute_stage against a behavioural model
// Optional feature macro: EXECUTE_NOR_EN (changes expected funct 0x27 result).
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_ctl;
  logic [2:0]  m_ctl;
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npcout;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] s_extendout;
  logic [4:0]  instrout_2016;
  logic [4:0]  instrout_1511;
  logic [1:0]  wb_ctlout;
  logic        branch;
  logic        memread;
  logic        memwrite;
  logic [31:0] EX_MEM_NPC;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2out;
  logic [4:0]  five_bit_muxout;

  int n_assert = 0;
  int n_fail   = 0;

  execute_stage dut (
    .clk             (clk),
    .rst             (rst),
    .wb_ctl          (wb_ctl),
    .m_ctl           (m_ctl),
    .regdst          (regdst),
    .alusrc          (alusrc),
    .aluop           (aluop),
    .npcout          (npcout),
    .rdata1          (rdata1),
    .rdata2          (rdata2),
    .s_extendout     (s_extendout),
    .instrout_2016   (instrout_2016),
    .instrout_1511   (instrout_1511),
    .wb_ctlout       (wb_ctlout),
    .branch          (branch),
    .memread         (memread),
    .memwrite        (memwrite),
    .EX_MEM_NPC      (EX_MEM_NPC),
    .zero            (zero),
    .alu_result      (alu_result),
    .rdata2out       (rdata2out),
    .five_bit_muxout (five_bit_muxout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the instruction-level meaning of aluop/funct.
  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a;
    sb = b;
    if (op == 2'b01) return a - b;
    if (op != 2'b10) return a + b;
    if (fn == 6'h20) return a + b;
    if (fn == 6'h22) return a - b;
    if (fn == 6'h24) return a & b;
    if (fn == 6'h25) return a | b;
    if (fn == 6'h2A) return (sa < sb) ? 32'd1 : 32'd0;
`ifdef EXECUTE_NOR_EN
    if (fn == 6'h27) return ~(a | b);
`endif
    return 32'd0;
  endfunction

  logic [31:0] e_res, e_npc;
  logic [4:0]  e_dest;
  logic        e_zero;

  // Clock one instruction through and compare every output with the model.
  task automatic step(input string tag);
    logic [31:0] b;
    b      = alusrc ? s_extendout : rdata2;
    e_res  = ref_alu(aluop, s_extendout[5:0], rdata1, b);
    e_zero = (e_res == 32'd0);
    e_npc  = npcout + s_extendout * 4;
    e_dest = regdst ? instrout_1511 : instrout_2016;
    @(posedge clk);
    #1;
    chk({tag, ".alu_result"}, alu_result, e_res);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
    chk({tag, ".npc"}, EX_MEM_NPC, e_npc);
    chk({tag, ".dest"}, {27'd0, five_bit_muxout}, {27'd0, e_dest});
    chk({tag, ".rdata2out"}, rdata2out, rdata2);
    chk({tag, ".wb"}, {30'd0, wb_ctlout}, {30'd0, wb_ctl});
    chk({tag, ".m"}, {29'd0, branch, memread, memwrite}, {29'd0, m_ctl});
  endtask

  task automatic randomize_inputs();
    logic [5:0] fn_tab [8];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00, 6'h3F};
    wb_ctl        = 2'($urandom);
    m_ctl         = 3'($urandom);
    regdst        = 1'($urandom);
    alusrc        = 1'($urandom);
    aluop         = 2'($urandom);
    npcout        = $urandom;
    rdata1        = $urandom;
    rdata2        = ($urandom_range(0, 3) == 0) ? rdata1 : $urandom;
    s_extendout   = $urandom;
    s_extendout[5:0] = fn_tab[$urandom_range(0, 7)];
    instrout_2016 = 5'($urandom);
    instrout_1511 = 5'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".alu_result"}, alu_result, 32'd0);
    chk({tag, ".zero"}, {31'd0, zero}, 32'd0);
    chk({tag, ".npc"}, EX_MEM_NPC, 32'd0);
    chk({tag, ".dest"}, {27'd0, five_bit_muxout}, 32'd0);
    chk({tag, ".rdata2out"}, rdata2out, 32'd0);
    chk({tag, ".wb"}, {30'd0, wb_ctlout}, 32'd0);
    chk({tag, ".m"}, {29'd0, branch, memread, memwrite}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    randomize_inputs();
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // R-type add
    randomize_inputs();
    aluop = 2'b10; alusrc = 1'b0; rdata1 = 32'd5; rdata2 = 32'd7;
    s_extendout = 32'h20; regdst = 1'b1; instrout_1511 = 5'd3;
    step("radd");
    chk("radd.lit_res", alu_result, 32'd12);
    chk("radd.lit_zero", {31'd0, zero}, 32'd0);
    chk("radd.lit_dest", {27'd0, five_bit_muxout}, 32'd3);
    chk("radd.lit_rd2", rdata2out, 32'd7);

    // beq
    randomize_inputs();
    aluop = 2'b01; alusrc = 1'b0; rdata1 = 32'd9; rdata2 = 32'd9;
    npcout = 32'h100; s_extendout = 32'd4; m_ctl = 3'b100;
    step("beq");
    chk("beq.lit_res", alu_result, 32'd0);
    chk("beq.lit_zero", {31'd0, zero}, 32'd1);
    chk("beq.lit_npc", EX_MEM_NPC, 32'h110);
    chk("beq.lit_branch", {31'd0, branch}, 32'd1);

    // lw with negative offset
    randomize_inputs();
    aluop = 2'b00; alusrc = 1'b1; rdata1 = 32'h1000; s_extendout = 32'hFFFF_FFFC;
    regdst = 1'b0; instrout_2016 = 5'd9; m_ctl = 3'b010; wb_ctl = 2'b11;
    step("lw");
    chk("lw.lit_res", alu_result, 32'hFFC);
    chk("lw.lit_dest", {27'd0, five_bit_muxout}, 32'd9);
    chk("lw.lit_memread", {31'd0, memread}, 32'd1);
    chk("lw.lit_wb", {30'd0, wb_ctlout}, 32'd3);

    // slt signed, both orders
    randomize_inputs();
    aluop = 2'b10; alusrc = 1'b0; s_extendout = 32'h2A;
    rdata1 = 32'hFFFF_FFFF; rdata2 = 32'd1;
    step("slt");
    chk("slt.lit_res", alu_result, 32'd1);
    rdata1 = 32'd1; rdata2 = 32'hFFFF_FFFF;
    step("slt_swap");
    chk("slt_swap.lit_res", alu_result, 32'd0);
    chk("slt_swap.lit_zero", {31'd0, zero}, 32'd1);

    // nor
    randomize_inputs();
    aluop = 2'b10; alusrc = 1'b0; s_extendout = 32'h27; rdata1 = 32'd0; rdata2 = 32'd0;
    step("nor");
`ifdef EXECUTE_NOR_EN
    chk("nor.lit_res", alu_result, 32'hFFFF_FFFF);
    chk("nor.lit_zero", {31'd0, zero}, 32'd0);
`else
    chk("nor.lit_res", alu_result, 32'd0);
    chk("nor.lit_zero", {31'd0, zero}, 32'd1);
`endif

    // branch adder wrap and lost top offset bits
    randomize_inputs();
    npcout = 32'hFFFF_FFF0; s_extendout = 32'h4000_0008;
    step("npc_wrap");
    chk("npc_wrap.lit", EX_MEM_NPC, 32'h0000_0010);

    // reset in the middle of a stream of valid instructions
    randomize_inputs();
    step("pre_rst");
    randomize_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("mid_reset");
    rst = 1'b0;

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
